// File: rtl/axilite_arbiter_rr.sv
// Round-robin arbiter that serialises NUM_REQ request/response clients onto one AXI4-Lite master port.
// Optional macro AXILITE_ARB_ADDR_CHECK_EN: reject addresses outside 0x10000..0x1FFFF or misaligned with DECERR.
`timescale 1ns/1ps
module axilite_arbiter_rr #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [DATA_WIDTH-1:0]          resp_rdata,
    output logic [1:0]                     resp_resp,
    output logic [ADDR_WIDTH-1:0]          M_AXI_AWADDR,
    output logic [2:0]                     M_AXI_AWPROT,
    output logic                           M_AXI_AWVALID,
    input  logic                           M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]          M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
    output logic                           M_AXI_WVALID,
    input  logic                           M_AXI_WREADY,
    input  logic [1:0]                     M_AXI_BRESP,
    input  logic                           M_AXI_BVALID,
    output logic                           M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]          M_AXI_ARADDR,
    output logic [2:0]                     M_AXI_ARPROT,
    output logic                           M_AXI_ARVALID,
    input  logic                           M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]          M_AXI_RDATA,
    input  logic [1:0]                     M_AXI_RRESP,
    input  logic                           M_AXI_RVALID,
    output logic                           M_AXI_RREADY
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WRESP = 3'd2,
        S_READ  = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         last_q, last_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;

    logic                  found_s;
    logic [GW-1:0]         pick_s;
    logic [GW-1:0]         cand_s;
    logic                  aw_done_n_s;
    logic                  w_done_n_s;

    function automatic logic [GW-1:0] rot_idx(input logic [GW-1:0] base, input int k);
        int sum;
        sum = (int'(base) + 1 + k) % NUM_REQ;
        return GW'(sum);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Rotating priority search: first requester above the last grant
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        cand_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = rot_idx(last_q, k);
            if (!found_s && req_valid[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // AW and W complete independently; track each one's handshake
    always_comb begin
        aw_done_n_s = aw_done_q | (awvalid_q & M_AXI_AWREADY);
        w_done_n_s  = w_done_q  | (wvalid_q  & M_AXI_WREADY);
    end

`ifdef AXILITE_ARB_ADDR_CHECK_EN
    logic addr_ok_s;

    // Address is legal only inside the register window and word aligned
    always_comb begin
        addr_ok_s = (addr_q >= ADDR_WIDTH'(32'h0001_0000)) &&
                    (addr_q <= ADDR_WIDTH'(32'h0001_FFFF)) &&
                    (addr_q[1:0] == 2'b00);
    end
`endif

    // Next-state and next-output logic of the transaction FSM
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        req_ready_d  = '0;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;

        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    grant_d     = pick_s;
                    req_ready_d = onehot(pick_s);
                    addr_d      = req_addr[int'(pick_s)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d     = req_wdata[int'(pick_s)*DATA_WIDTH +: DATA_WIDTH];
                    wstrb_d     = req_wstrb[int'(pick_s)*SW +: SW];
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    state_d     = req_write[pick_s] ? S_WRITE : S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
`ifdef AXILITE_ARB_ADDR_CHECK_EN
                if (!addr_ok_s) begin
                    resp_valid_d = onehot(grant_q);
                    rdata_d      = '0;
                    resp_d       = 2'b11;
                    state_d      = S_DONE;
                end else
`endif
                if (aw_done_n_s && w_done_n_s) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = S_WRESP;
                end else begin
                    awvalid_d = ~aw_done_n_s;
                    wvalid_d  = ~w_done_n_s;
                    aw_done_d = aw_done_n_s;
                    w_done_d  = w_done_n_s;
                end
            end
            S_WRESP: begin
                if (bready_q && M_AXI_BVALID) begin
                    bready_d     = 1'b0;
                    resp_d       = M_AXI_BRESP;
                    rdata_d      = '0;
                    resp_valid_d = onehot(grant_q);
                    state_d      = S_DONE;
                end else begin
                    bready_d = 1'b1;
                end
            end
            S_READ: begin
`ifdef AXILITE_ARB_ADDR_CHECK_EN
                if (!addr_ok_s) begin
                    resp_valid_d = onehot(grant_q);
                    rdata_d      = '0;
                    resp_d       = 2'b11;
                    state_d      = S_DONE;
                end else
`endif
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            S_RDATA: begin
                if (rready_q && M_AXI_RVALID) begin
                    rready_d     = 1'b0;
                    rdata_d      = M_AXI_RDATA;
                    resp_d       = M_AXI_RRESP;
                    resp_valid_d = onehot(grant_q);
                    state_d      = S_DONE;
                end else begin
                    rready_d = 1'b1;
                end
            end
            S_DONE: begin
                if (resp_ready[grant_q]) begin
                    resp_valid_d = '0;
                    last_d       = grant_q;
                    state_d      = S_IDLE;
                end else begin
                    resp_valid_d = onehot(grant_q);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every valid/ready and discards the response
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_q       <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
            resp_q       <= 2'b00;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = rdata_q;
    assign resp_resp     = resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
